// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
// Imported by the slot and the top level.
package stream_demux_pkg;

    localparam int DROP_CNT_W = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot for a demux channel.
// A drain and a load in the same cycle keep the slot full.
module demux_out_slot
    import stream_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         can_load
);

    slot_state_e  state_q;
    slot_state_e  state_d;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (out_ready && !load) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // Data is not cleared on drain; it holds the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;
    assign can_load  = !out_valid || out_ready;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N valid/ready demultiplexer with per-channel slots.
// Out-of-range selects are accepted, dropped and counted.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int SEL_W = sel_width(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [N*W-1:0]        out_data,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam logic [SEL_W:0] N_CMP = (SEL_W+1)'(N);

    logic [N-1:0]          sel_hot;
    logic [N-1:0]          can_load;
    logic [N-1:0]          load;
    logic                  sel_in_range;
    logic                  sel_can_load;
    logic                  xfer;
    logic                  drop;
    logic [DROP_CNT_W-1:0] drop_q;

    assign sel_in_range = ({1'b0, in_sel} < N_CMP);

    always_comb begin
        sel_hot      = '0;
        sel_can_load = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_hot[k]   = 1'b1;
                sel_can_load = can_load[k];
            end
        end
    end

    // Dropped beats never stall the input.
    assign in_ready = !reset &&
                      (sel_in_range ? sel_can_load : 1'b1);
    assign xfer     = in_valid && in_ready;
    assign load     = xfer ? sel_hot : '0;
    assign drop     = xfer && !sel_in_range;

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_out_slot #(
            .W(W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[k]),
            .load_data(in_data),
            .out_valid(out_valid[k]),
            .out_ready(out_ready[k]),
            .out_data (out_data[k*W +: W]),
            .can_load (can_load[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux.
// Uses an N=2 instance for routing and an N=3 one for drops.
module tb_stream_demux;

    logic        clk;
    logic        reset;

    logic        v2;
    logic        ir2;
    logic [7:0]  d2;
    logic        s2;
    logic [1:0]  ov2;
    logic [1:0]  or2;
    logic [15:0] od2;
    logic [7:0]  dc2;

    logic        v3;
    logic        ir3;
    logic [7:0]  d3;
    logic [1:0]  s3;
    logic [2:0]  ov3;
    logic [2:0]  or3;
    logic [23:0] od3;
    logic [7:0]  dc3;

    int total;
    int bad;

    stream_demux #(.N(2), .W(8)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v2),
        .in_ready  (ir2),
        .in_data   (d2),
        .in_sel    (s2),
        .out_valid (ov2),
        .out_ready (or2),
        .out_data  (od2),
        .drop_count(dc2)
    );

    stream_demux #(.N(3), .W(8)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v3),
        .in_ready  (ir3),
        .in_data   (d3),
        .in_sel    (s3),
        .out_valid (ov3),
        .out_ready (or3),
        .out_data  (od3),
        .drop_count(dc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        v2 = 1'b1; d2 = 8'h00; s2 = 1'b0; or2 = 2'b11;
        v3 = 1'b0; d3 = 8'h00; s3 = 2'd0; or3 = 3'b111;

        tick();
        tick();
        chk("rst_ov2", 32'(ov2), 32'h0);
        chk("rst_od2", 32'(od2), 32'h0);
        chk("rst_dc2", 32'(dc2), 32'h0);
        chk("rst_ir2", 32'(ir2), 32'h0);
        chk("rst_dc3", 32'(dc3), 32'h0);

        reset = 1'b0;
        d2 = 8'hA5; s2 = 1'b0;
        #1;
        chk("rel_ir2", 32'(ir2), 32'h1);
        tick();
        d2 = 8'h3C; s2 = 1'b1;
        #1;
        chk("r0_ir", 32'(ir2), 32'h1);
        chk("r0_ov", 32'(ov2), 32'h1);
        chk("r0_od", 32'(od2[7:0]), 32'hA5);
        tick();
        v2 = 1'b0;
        chk("r1_ov", 32'(ov2), 32'h2);
        chk("r1_od", 32'(od2[15:8]), 32'h3C);
        tick();
        chk("r_idle_ov", 32'(ov2), 32'h0);
        chk("r_hold_od", 32'(od2), 32'h3CA5);

        or2 = 2'b10;
        v2 = 1'b1; d2 = 8'h11; s2 = 1'b0;
        #1;
        chk("bp_ir1", 32'(ir2), 32'h1);
        tick();
        d2 = 8'h22;
        #1;
        chk("bp_ir2", 32'(ir2), 32'h0);
        chk("bp_ov", 32'(ov2[0]), 32'h1);
        chk("bp_od", 32'(od2[7:0]), 32'h11);
        tick();
        chk("bp_hold_od", 32'(od2[7:0]), 32'h11);
        chk("bp_hold_ir", 32'(ir2), 32'h0);
        or2 = 2'b11;
        #1;
        chk("bp_rel_ir", 32'(ir2), 32'h1);
        tick();
        v2 = 1'b0;
        chk("bp_b2b_ov", 32'(ov2[0]), 32'h1);
        chk("bp_b2b_od", 32'(od2[7:0]), 32'h22);

        or2 = 2'b10;
        v2 = 1'b1; d2 = 8'h77; s2 = 1'b1;
        #1;
        chk("nb_ir", 32'(ir2), 32'h1);
        tick();
        v2 = 1'b0;
        chk("nb_ov", 32'(ov2), 32'h3);
        chk("nb_od1", 32'(od2[15:8]), 32'h77);
        chk("nb_od0", 32'(od2[7:0]), 32'h22);
        tick();
        chk("nb_drain_ov", 32'(ov2), 32'h1);
        chk("nb_ch0_od", 32'(od2[7:0]), 32'h22);
        chk("pow2_dc2", 32'(dc2), 32'h0);

        v3 = 1'b1; d3 = 8'h5A; s3 = 2'd2;
        tick();
        v3 = 1'b0;
        chk("n3_ov", 32'(ov3), 32'h4);
        chk("n3_od", 32'(od3[23:16]), 32'h5A);
        tick();
        chk("n3_drain", 32'(ov3), 32'h0);

        s3 = 2'd3;
        tick();
        chk("idle_sel3_dc", 32'(dc3), 32'h0);

        v3 = 1'b1; d3 = 8'hEE;
        for (int i = 1; i <= 300; i++) begin
            chk("drop_ir", 32'(ir3), 32'h1);
            tick();
            chk("drop_ov", 32'(ov3), 32'h0);
            chk("drop_dc", 32'(dc3),
                (i > 255) ? 32'd255 : 32'(i));
        end
        v3 = 1'b0;
        tick();
        chk("drop_sat", 32'(dc3), 32'd255);

        or2 = 2'b00;
        v2 = 1'b1; d2 = 8'h88; s2 = 1'b1;
        tick();
        v2 = 1'b0;
        chk("mid_full_ov", 32'(ov2), 32'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ov2", 32'(ov2), 32'h0);
        chk("mid_rst_od2", 32'(od2), 32'h0);
        chk("mid_rst_dc3", 32'(dc3), 32'h0);
        chk("mid_rst_ov3", 32'(ov3), 32'h0);
        or2 = 2'b11;
        tick();
        chk("mid_no_deliver", 32'(ov2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
